// File: rtl/mem_port_arbiter_if.sv
// Bundle of signals between two memory requesters, the arbiter and a single-port
// word memory.
//   Port 0 / port 1 requester side:
//     reqX, weX, addrX, wdataX, lockX  - request with its command
//     gntX                             - request accepted this cycle
//     rdataX, rvalidX                  - registered read response
//   Memory side:
//     mem_addr, mem_in, mem_we         - driven by the arbiter
//     mem_out                          - async read data from the memory
// Modports:
//   slave  - the arbiter
//   master - the environment, meaning the requesters plus the memory
interface mem_port_arbiter_if #(
  parameter int unsigned N = 32,
  parameter int unsigned M = 10
);
  logic         req0;
  logic         we0;
  logic [M-1:0] addr0;
  logic [N-1:0] wdata0;
  logic         lock0;
  logic         gnt0;
  logic [N-1:0] rdata0;
  logic         rvalid0;

  logic         req1;
  logic         we1;
  logic [M-1:0] addr1;
  logic [N-1:0] wdata1;
  logic         lock1;
  logic         gnt1;
  logic [N-1:0] rdata1;
  logic         rvalid1;

  logic [M-1:0] mem_addr;
  logic [N-1:0] mem_in;
  logic         mem_we;
  logic [N-1:0] mem_out;

  modport slave (
    input  req0, we0, addr0, wdata0, lock0,
    input  req1, we1, addr1, wdata1, lock1,
    input  mem_out,
    output gnt0, rdata0, rvalid0,
    output gnt1, rdata1, rvalid1,
    output mem_addr, mem_in, mem_we
  );

  modport master (
    output req0, we0, addr0, wdata0, lock0,
    output req1, we1, addr1, wdata1, lock1,
    output mem_out,
    input  gnt0, rdata0, rvalid0,
    input  gnt1, rdata1, rvalid1,
    input  mem_addr, mem_in, mem_we
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one single-port word memory (async read,
// posedge write) between an instruction-fetch port (0) and a data port (1).
// A requester may set its lock bit so that it keeps the grant on the next
// cycle, which allows read-modify-write sequences.
// Ports:
//   clock - system clock, all state changes on the posedge
//   reset - asynchronous active-high reset
//   bus   - mem_port_arbiter_if.slave: both request ports, their registered
//           read responses, and the memory address/data/write-enable
module mem_port_arbiter #(
  parameter int unsigned N = 32,
  parameter int unsigned M = 10
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t       state_q;
  logic         prio_q;
  logic [N-1:0] rdata0_q;
  logic [N-1:0] rdata1_q;
  logic         rvalid0_q;
  logic         rvalid1_q;

  logic         win0;
  logic         win1;
  logic [M-1:0] addr_sel;
  logic [N-1:0] wdata_sel;
  logic         we_sel;

  // Winner selection. Reset gates the result here so that grants and the
  // memory write strobe fall as soon as reset rises, without a clock edge.
  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    case (state_q)
      ARB: begin
        if (bus.req0 && bus.req1) begin
          win0 = ~prio_q;
          win1 = prio_q;
        end else begin
          win0 = bus.req0;
          win1 = bus.req1;
        end
      end
      LOCK0: begin
        win0 = bus.req0;
        win1 = ~bus.req0 & bus.req1;
      end
      LOCK1: begin
        win1 = bus.req1;
        win0 = ~bus.req1 & bus.req0;
      end
      default: begin
        win0 = 1'b0;
        win1 = 1'b0;
      end
    endcase
    if (reset) begin
      win0 = 1'b0;
      win1 = 1'b0;
    end
  end

  // Memory port mux. With no winner it shows port 0's address and data, but
  // the write strobe stays low.
  always_comb begin
    addr_sel  = bus.addr0;
    wdata_sel = bus.wdata0;
    we_sel    = 1'b0;
    if (win1) begin
      addr_sel  = bus.addr1;
      wdata_sel = bus.wdata1;
      we_sel    = bus.we1;
    end else if (win0) begin
      we_sel    = bus.we0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ARB;
      prio_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      rvalid0_q <= win0 & ~bus.we0;
      rvalid1_q <= win1 & ~bus.we1;
      if (win0 && !bus.we0) rdata0_q <= bus.mem_out;
      if (win1 && !bus.we1) rdata1_q <= bus.mem_out;

      // The pointer moves to the loser only on grants made from ARB. The
      // value prio = ~w is simply win0.
      if (state_q == ARB && (win0 || win1)) prio_q <= win0;

      if (win0)      state_q <= bus.lock0 ? LOCK0 : ARB;
      else if (win1) state_q <= bus.lock1 ? LOCK1 : ARB;
      else           state_q <= ARB;
    end
  end

  assign bus.gnt0     = win0;
  assign bus.gnt1     = win1;
  assign bus.mem_addr = addr_sel;
  assign bus.mem_in   = wdata_sel;
  assign bus.mem_we   = we_sel;
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;
  assign bus.rvalid0  = rvalid0_q;
  assign bus.rvalid1  = rvalid1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic clock;
  logic reset;

  mem_port_arbiter_if #(.N(32), .M(10)) bus ();

  mem_port_arbiter #(.N(32), .M(10)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory: word i initially holds i/4, async read, posedge write.
  logic [31:0] mem [1024];
  assign bus.mem_out = mem[bus.mem_addr];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i) >> 2;
    forever begin
      @(posedge clock);
      if (bus.mem_we === 1'b1) mem[bus.mem_addr] <= bus.mem_in;
    end
  end

  typedef struct {
    bit          port;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input bit p, input logic [31:0] d);
    exp_t e;
    e.port = p;
    e.data = d;
    q.push_back(e);
  endtask

  task automatic pop_cmp(input bit p, input logic [31:0] d);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL rvalid%0d unexpected: got data %h, expected no response", p, d);
    end else begin
      e = q.pop_front();
      if (e.port != p || e.data !== d) begin
        errors++;
        $display("FAIL rresp: got port %0d data %h expected port %0d data %h", p, d, e.port, e.data);
      end
    end
  endtask

  // Monitor: samples responses away from the active edge.
  initial begin
    forever begin
      @(negedge clock);
      if (bus.rvalid0 === 1'b1) pop_cmp(1'b0, bus.rdata0);
      if (bus.rvalid1 === 1'b1) pop_cmp(1'b1, bus.rdata1);
    end
  end

  // Drive one cycle's inputs at posedge+1, check the grant and the memory
  // port at posedge+3, then advance to the next posedge+1.
  task automatic step(
    input logic r0, input logic w0, input logic [9:0] a0, input logic [31:0] d0, input logic l0,
    input logic r1, input logic w1, input logic [9:0] a1, input logic [31:0] d1, input logic l1,
    input logic eg0, input logic eg1, input string tag);
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0; bus.lock0 = l0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1; bus.lock1 = l1;
    #2;
    chk({tag, " gnt0"}, 32'(bus.gnt0), 32'(eg0));
    chk({tag, " gnt1"}, 32'(bus.gnt1), 32'(eg1));
    if (eg1) begin
      chk({tag, " mem_addr"}, 32'(bus.mem_addr), 32'(a1));
      chk({tag, " mem_we"}, 32'(bus.mem_we), 32'(w1));
    end else if (eg0) begin
      chk({tag, " mem_addr"}, 32'(bus.mem_addr), 32'(a0));
      chk({tag, " mem_we"}, 32'(bus.mem_we), 32'(w0));
    end else begin
      chk({tag, " mem_we idle"}, 32'(bus.mem_we), 32'd0);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input string tag);
    step(0, 0, 10'd0, 32'd0, 0, 0, 0, 10'd0, 32'd0, 0, 0, 0, tag);
  endtask

  initial begin
    reset = 1'b1;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 10'd3; bus.wdata0 = 32'hFFFF; bus.lock0 = 1'b0;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 10'd3; bus.wdata1 = 32'hFFFF; bus.lock1 = 1'b0;
    #3;
    chk("reset gnt0", 32'(bus.gnt0), 32'd0);
    chk("reset gnt1", 32'(bus.gnt1), 32'd0);
    chk("reset mem_we", 32'(bus.mem_we), 32'd0);
    chk("reset rvalid0", 32'(bus.rvalid0), 32'd0);
    chk("reset rvalid1", 32'(bus.rvalid1), 32'd0);
    chk("reset rdata0", bus.rdata0, 32'd0);
    chk("reset rdata1", bus.rdata1, 32'd0);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;

    // Single read on port 0.
    push(0, 32'd2);
    step(1, 0, 10'd8, 32'd0, 0, 0, 0, 10'd0, 32'd0, 0, 1, 0, "rd0");
    idle("rd0 idle");

    // Write then read back on port 1.
    step(0, 0, 10'd0, 32'd0, 0, 1, 1, 10'd12, 32'hDEADBEEF, 0, 0, 1, "wr1");
    push(1, 32'hDEADBEEF);
    step(0, 0, 10'd0, 32'd0, 0, 1, 0, 10'd12, 32'd0, 0, 0, 1, "rd1");
    idle("rd1 idle");

    // Reset pulse, then a 4-cycle tie.
    reset = 1'b1; #2; reset = 1'b0;
    @(posedge clock); #1;
    push(0, 32'd1);
    step(1, 0, 10'd4, 32'd0, 0, 1, 0, 10'd16, 32'd0, 0, 1, 0, "tie a");
    push(1, 32'd4);
    step(1, 0, 10'd4, 32'd0, 0, 1, 0, 10'd16, 32'd0, 0, 0, 1, "tie b");
    push(0, 32'd1);
    step(1, 0, 10'd4, 32'd0, 0, 1, 0, 10'd16, 32'd0, 0, 1, 0, "tie c");
    push(1, 32'd4);
    step(1, 0, 10'd4, 32'd0, 0, 1, 0, 10'd16, 32'd0, 0, 0, 1, "tie d");
    idle("tie idle");

    // Lock: a port 0 grant first points the tie at port 1.
    push(0, 32'd0);
    step(1, 0, 10'd0, 32'd0, 0, 0, 0, 10'd0, 32'd0, 0, 1, 0, "lk pre");
    push(1, 32'd5);
    step(1, 0, 10'd20, 32'd0, 0, 1, 0, 10'd20, 32'd0, 1, 0, 1, "lk rd");
    step(1, 0, 10'd20, 32'd0, 0, 1, 1, 10'd20, 32'hCAFE0001, 0, 0, 1, "lk wr");
    push(0, 32'hCAFE0001);
    step(1, 0, 10'd20, 32'd0, 0, 0, 0, 10'd0, 32'd0, 0, 1, 0, "lk p0");

    // A lock is dropped when the holder idles.
    push(0, 32'd2);
    step(1, 0, 10'd8, 32'd0, 1, 0, 0, 10'd0, 32'd0, 0, 1, 0, "drop lk0");
    push(1, 32'd1);
    step(0, 0, 10'd0, 32'd0, 0, 1, 0, 10'd4, 32'd0, 0, 0, 1, "drop g1");
    push(1, 32'd1);
    step(1, 0, 10'd16, 32'd0, 0, 1, 0, 10'd4, 32'd0, 0, 0, 1, "drop arb");
    push(0, 32'd4);
    step(1, 0, 10'd16, 32'd0, 0, 0, 0, 10'd0, 32'd0, 0, 1, 0, "drop p0");

    // Top address and a read directly after a write to it.
    step(1, 1, 10'd1023, 32'h12345678, 0, 0, 0, 10'd0, 32'd0, 0, 1, 0, "top wr");
    push(0, 32'h12345678);
    step(1, 0, 10'd1023, 32'd0, 0, 0, 0, 10'd0, 32'd0, 0, 1, 0, "top rd");

    // Port 1 read, whose response the reset below clears before it is sampled.
    step(0, 0, 10'd0, 32'd0, 0, 1, 0, 10'd8, 32'd0, 0, 0, 1, "pre rst");

    // Async reset in the middle of a granted write.
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 10'd40; bus.wdata0 = 32'h55; bus.lock0 = 1'b0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.lock1 = 1'b0;
    #1;
    chk("mid gnt0", 32'(bus.gnt0), 32'd1);
    chk("mid mem_we", 32'(bus.mem_we), 32'd1);
    chk("mid rvalid1", 32'(bus.rvalid1), 32'd1);
    chk("mid rdata1", bus.rdata1, 32'd2);
    #1;
    reset = 1'b1;
    #1;
    chk("arst mem_we", 32'(bus.mem_we), 32'd0);
    chk("arst gnt0", 32'(bus.gnt0), 32'd0);
    chk("arst rvalid0", 32'(bus.rvalid0), 32'd0);
    chk("arst rvalid1", 32'(bus.rvalid1), 32'd0);
    chk("arst rdata0", bus.rdata0, 32'd0);
    chk("arst rdata1", bus.rdata1, 32'd0);
    @(posedge clock); #1;
    bus.req0 = 1'b0;
    reset = 1'b0;

    // After release, port 0 wins the first tie. Address 40 was not written.
    push(0, 32'd10);
    step(1, 0, 10'd40, 32'd0, 0, 1, 0, 10'd4, 32'd0, 0, 1, 0, "post tie");
    push(1, 32'd1);
    step(0, 0, 10'd0, 32'd0, 0, 1, 0, 10'd4, 32'd0, 0, 0, 1, "post p1");
    idle("end idle a");
    idle("end idle b");

    chk("scoreboard drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port word memory (async read, posedge-clock write, N-bit data, M-bit word address) between two requesters.
- Port 0 is instruction fetch; port 1 is data load/store.
- Arbitration is round-robin, with an optional lock that holds the grant for read-modify-write sequences.
- Read data is returned through registered response ports. The memory's own ports are driven directly by this block.

Parameters:
- N, 32, data width (must match the memory).
- M, 10, word-address width (must match the memory).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 request; held high with stable addr0/we0/wdata0/lock0 until gnt0.
- we0  in  1  port 0 write enable (1 = write, 0 = read).
- addr0  in  M  port 0 word address.
- wdata0  in  N  port 0 write data.
- lock0  in  1  port 0 requests to keep the grant in the next cycle.
- gnt0  out  1  port 0 request accepted this cycle (combinational).
- rdata0  out  N  port 0 registered read data.
- rvalid0  out  1  rdata0 valid this cycle (one-cycle pulse).
- req1, we1, addr1, wdata1, lock1, gnt1, rdata1, rvalid1: same as port 0, for port 1.
- mem_addr  out  M  to memory addr.
- mem_in  out  N  to memory in.
- mem_we  out  1  to memory we.
- mem_out  in  N  from memory out.

Behaviour:
- State: FSM {ARB, LOCK0, LOCK1}; 1-bit priority pointer prio (0 = port 0 wins a tie).
- Reset (async, immediate):
  - state = ARB, prio = 0.
  - rdata0 = rdata1 = 0, rvalid0 = rvalid1 = 0.
  - While reset is high, gnt0 = gnt1 = 0 and mem_we = 0.
  - Memory contents are not touched.
- Winner selection, combinational, per cycle:
  - ARB: only one req high → that port wins; both high → the port indexed by prio wins.
  - LOCK0: port 0 wins if req0 = 1, else port 1 if req1 = 1.
  - LOCK1: the mirror of LOCK0.
  - No req → no winner.
- Outputs with a winner w:
  - gnt_w = 1, the other gnt = 0.
  - mem_addr = addr_w, mem_in = wdata_w, mem_we = we_w.
- Outputs with no winner: gnt0 = gnt1 = 0, mem_we = 0, mem_addr = addr0, mem_in = wdata0.
- Latency: one access per cycle, always.
  - Write: commits at the posedge ending the grant cycle.
  - Read: mem_out is sampled at that posedge into rdata_w, and rvalid_w = 1 for exactly the next cycle.
  - A granted write produces no rvalid.
- Non-granted port: rdata holds its last value and rvalid = 0.
- Back-to-back grants to one port give back-to-back rvalid pulses.
- Pointer update at the posedge of a grant cycle:
  - prio = ~w if the grant came from the ARB state.
  - prio is unchanged while in LOCK0/LOCK1.
  - With no grant, prio is unchanged.
- FSM transitions at the posedge:
  - Winner w with lock_w = 1 → LOCKw.
  - Any grant with lock = 0 → ARB.
  - No grant → ARB (a lock is dropped if the holder idles).
  - In LOCKw the other port is granted only if req_w = 0; the transition rule then applies to that port's lock.
- Hazards and boundaries:
  - A read of an address written in the preceding cycle returns the new data.
  - Address width is M bits, so there is no wrap logic; address 2^M-1 is legal.
- Reset mid-operation:
  - A pending rvalid is cleared.
  - A write whose grant cycle is cut by reset before the edge is not committed; mem_we is forced 0.
  - After reset release, port 0 wins the first tie.
- Starvation bound: without lock, a continuously requesting port waits at most 1 cycle.

Test Plan:
- Reset then single read: reset pulse, then req0 = 1, we0 = 0, addr0 = 8 for one cycle → gnt0 = 1 that cycle; next cycle rvalid0 = 1 and rdata0 = 2. Addr 8 holds 2 from the memory's initial contents.
- Write then read-back on port 1: write wdata1 = 32'hDEADBEEF to addr1 = 12, then read addr1 = 12 → gnt1 = 1 in both cycles; the cycle after the read has rvalid1 = 1 and rdata1 = 32'hDEADBEEF; rvalid1 = 0 after the write.
- Tie round-robin: req0 = req1 = 1 held 4 cycles right after reset, both reads (addr0 = 4, addr1 = 16) → grants alternate 0,1,0,1; rdata0 = 1 and rdata1 = 4 on their rvalid pulses.
- Lock: port 1 reads addr 20 with lock1 = 1 while req0 = 1, then writes addr 20 with lock1 = 0 → port 1 granted 2 consecutive cycles, gnt0 = 0 during both, port 0 granted in the third cycle. A port 0 read of addr 20 then returns the port 1 write data.
- Lock dropped on idle: port 0 granted with lock0 = 1, next cycle req0 = 0, req1 = 1 → gnt1 = 1 immediately; state returns to ARB.
- Async reset mid-write: assert reset mid-cycle during a granted port 0 write to addr 40 of 32'h55 → mem_we falls at once, rvalid0/1 = 0 and rdata0/1 = 0 without a clock edge; a later read of addr 40 returns 10.
